// File: rtl/segre_ctrl_fsm.sv
// Segre RV32I multicycle control sequencer.
// Walks IF->ID->EX->MEM->WB, waits on memory handshakes, counts retirements.
module segre_ctrl_fsm #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 halt_i,
   input  logic [6:0]           opcode_i,
   input  logic                 ifetch_ready_i,
   input  logic                 dmem_ready_i,
   output logic [2:0]           state_o,
   output logic                 ifetch_req_o,
   output logic                 ir_we_o,
   output logic                 dmem_req_o,
   output logic                 dmem_we_o,
   output logic                 rf_we_o,
   output logic                 pc_we_o,
   output logic                 illegal_instr_o,
   output logic                 mem_err_o,
   output logic [CNT_WIDTH-1:0] instret_o
);

   typedef enum logic [2:0] {
      IF_STATE  = 3'd0,
      ID_STATE  = 3'd1,
      EX_STATE  = 3'd2,
      MEM_STATE = 3'd3,
      WB_STATE  = 3'd4
   } fsm_state_e;

   typedef enum logic [6:0] {
      OPCODE_LOAD     = 7'h03,
      OPCODE_MISC_MEM = 7'h0f,
      OPCODE_OP_IMM   = 7'h13,
      OPCODE_AUIPC    = 7'h17,
      OPCODE_STORE    = 7'h23,
      OPCODE_OP       = 7'h33,
      OPCODE_LUI      = 7'h37,
      OPCODE_BRANCH   = 7'h63,
      OPCODE_JALR     = 7'h67,
      OPCODE_JAL      = 7'h6f,
      OPCODE_SYSTEM   = 7'h73
   } opcode_e;

   localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   fsm_state_e           state_q, state_d;
   logic [WAIT_W-1:0]    wait_q, wait_d;
   logic [6:0]           opcode_q, opcode_d;
   logic                 killed_q, killed_d;
   logic [CNT_WIDTH-1:0] instret_q, instret_d;
   logic                 timeout;

   // Opcode is one of the RV32I base major opcodes.
   function automatic logic op_known(input logic [6:0] op);
      case (op)
         OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM,
         OPCODE_AUIPC, OPCODE_STORE, OPCODE_OP,
         OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR,
         OPCODE_JAL, OPCODE_SYSTEM: return 1'b1;
         default:                   return 1'b0;
      endcase
   endfunction

   // Opcode produces a register-file result.
   function automatic logic op_writes_rf(input logic [6:0] op);
      case (op)
         OPCODE_LOAD, OPCODE_OP, OPCODE_OP_IMM,
         OPCODE_LUI, OPCODE_AUIPC, OPCODE_JAL,
         OPCODE_JALR: return 1'b1;
         default:     return 1'b0;
      endcase
   endfunction

   // Opcode needs the data-memory phase.
   function automatic logic op_is_mem(input logic [6:0] op);
      return (op == OPCODE_LOAD) || (op == OPCODE_STORE);
   endfunction

   assign timeout = (wait_q == WAIT_LAST);

   // State, wait counter, opcode latch, kill flag and retire counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= IF_STATE;
         wait_q    <= '0;
         opcode_q  <= OPCODE_OP_IMM;
         killed_q  <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         opcode_q  <= opcode_d;
         killed_q  <= killed_d;
         instret_q <= instret_d;
      end
   end

   // Next-state and bookkeeping for each phase.
   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      opcode_d  = opcode_q;
      killed_d  = killed_q;
      instret_d = instret_q;
      unique case (state_q)
         IF_STATE: begin
            if (halt_i) begin
               wait_d = '0;
            end else if (ifetch_ready_i) begin
               wait_d  = '0;
               state_d = ID_STATE;
            end else if (timeout) begin
               wait_d = '0;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ID_STATE: begin
            opcode_d = opcode_i;
            state_d  = EX_STATE;
         end
         EX_STATE: begin
            if (!op_known(opcode_q)) begin
               killed_d = 1'b1;
            end
            if (op_is_mem(opcode_q)) begin
               state_d = MEM_STATE;
            end else begin
               state_d = WB_STATE;
            end
         end
         MEM_STATE: begin
            if (dmem_ready_i) begin
               wait_d  = '0;
               state_d = WB_STATE;
            end else if (timeout) begin
               wait_d   = '0;
               killed_d = 1'b1;
               state_d  = WB_STATE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         WB_STATE: begin
            if (!killed_q) begin
               instret_d = instret_q + 1'b1;
            end
            killed_d = 1'b0;
            state_d  = IF_STATE;
         end
         default: begin
            wait_d   = '0;
            killed_d = 1'b0;
            state_d  = IF_STATE;
         end
      endcase
   end

   // Control strobes decoded from the current phase and handshakes.
   always_comb begin
      ifetch_req_o    = 1'b0;
      ir_we_o         = 1'b0;
      dmem_req_o      = 1'b0;
      dmem_we_o       = 1'b0;
      rf_we_o         = 1'b0;
      pc_we_o         = 1'b0;
      illegal_instr_o = 1'b0;
      mem_err_o       = 1'b0;
      unique case (state_q)
         IF_STATE: begin
            ifetch_req_o = !halt_i;
            ir_we_o      = !halt_i && ifetch_ready_i;
            mem_err_o    = !halt_i && !ifetch_ready_i && timeout;
         end
         EX_STATE: begin
            illegal_instr_o = !op_known(opcode_q);
         end
         MEM_STATE: begin
            dmem_req_o = 1'b1;
            dmem_we_o  = (opcode_q == OPCODE_STORE);
            mem_err_o  = !dmem_ready_i && timeout;
         end
         WB_STATE: begin
            pc_we_o = 1'b1;
            rf_we_o = !killed_q && op_writes_rf(opcode_q);
         end
         default: begin
            ifetch_req_o = 1'b0;
         end
      endcase
   end

   assign state_o   = state_q;
   assign instret_o = instret_q;

endmodule

// File: tb/tb_segre_ctrl_fsm.sv
// Bench for segre_ctrl_fsm: per-scenario tasks, expected output vectors
// queued as stimulus is driven and compared one cycle at a time.
module tb_segre_ctrl_fsm;

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        halt_i;
   logic [6:0]  opcode_i;
   logic        ifetch_ready_i;
   logic        dmem_ready_i;
   logic [2:0]  state_o;
   logic        ifetch_req_o;
   logic        ir_we_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic        rf_we_o;
   logic        pc_we_o;
   logic        illegal_instr_o;
   logic        mem_err_o;
   logic [31:0] instret_o;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] m;
   logic [42:0] exp_v;
   logic [42:0] obs;
   logic [42:0] sb[$];

   segre_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_WIDTH(32)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .halt_i          (halt_i),
      .opcode_i        (opcode_i),
      .ifetch_ready_i  (ifetch_ready_i),
      .dmem_ready_i    (dmem_ready_i),
      .state_o         (state_o),
      .ifetch_req_o    (ifetch_req_o),
      .ir_we_o         (ir_we_o),
      .dmem_req_o      (dmem_req_o),
      .dmem_we_o       (dmem_we_o),
      .rf_we_o         (rf_we_o),
      .pc_we_o         (pc_we_o),
      .illegal_instr_o (illegal_instr_o),
      .mem_err_o       (mem_err_o),
      .instret_o       (instret_o)
   );

   always #5 clk = ~clk;

   assign obs = {state_o, ifetch_req_o, ir_we_o, dmem_req_o, dmem_we_o,
                 rf_we_o, pc_we_o, illegal_instr_o, mem_err_o, instret_o};

   // state, req, ir_we, dreq, dwe, rf_we, pc_we, illegal, mem_err, instret
   function automatic logic [42:0] mk(
      input logic [2:0] s, input logic rq, input logic irw,
      input logic dq, input logic dw, input logic rf, input logic pc,
      input logic il, input logic me, input logic [31:0] n);
      return {s, rq, irw, dq, dw, rf, pc, il, me, n};
   endfunction

   task automatic test_reset();
      rst_i = 1'b1;
      halt_i = 1'b0;
      opcode_i = 7'h00;
      ifetch_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
      repeat (2) @(negedge clk);
      sb.push_back(mk(S_IF, 1, 0, 0, 0, 0, 0, 0, 0, 32'd0));
      #1; exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset: got %h want %h", obs, exp_v);
      end
      halt_i = 1'b1;
      ifetch_ready_i = 1'b1;
      dmem_ready_i = 1'b1;
      sb.push_back(mk(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, 32'd0));
      #1; exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL reset_halt: got %h want %h", obs, exp_v);
      end
      @(negedge clk);
      rst_i = 1'b0;
      halt_i = 1'b0;
      ifetch_ready_i = 1'b0;
      dmem_ready_i = 1'b0;
      m = 32'd0;
   endtask

   task automatic test_addi();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         halt_i = (c == 4);
         opcode_i = 7'h13;
         ifetch_ready_i = 1'b1;
         dmem_ready_i = (c != 0);
         case (c)
            0: sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
            1: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
            2: sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m));
            3: sb.push_back(mk(S_WB, 0, 0, 0, 0, 1, 1, 0, 0, m));
            default: sb.push_back(mk(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, m + 1));
         endcase
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL addi c%0d: got %h want %h", c, obs, exp_v);
         end
      end
      m = m + 1;
   endtask

   task automatic test_load();
      for (int c = 0; c < 7; c++) begin
         @(negedge clk);
         halt_i = 1'b0;
         opcode_i = 7'h03;
         ifetch_ready_i = (c == 0);
         dmem_ready_i = (c == 5);
         case (c)
            0: sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
            1: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
            2: sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m));
            3, 4, 5: sb.push_back(mk(S_MEM, 0, 0, 1, 0, 0, 0, 0, 0, m));
            default: sb.push_back(mk(S_WB, 0, 0, 0, 0, 1, 1, 0, 0, m));
         endcase
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL load c%0d: got %h want %h", c, obs, exp_v);
         end
      end
      m = m + 1;
   endtask

   task automatic test_store_branch();
      for (int c = 0; c < 11; c++) begin
         @(negedge clk);
         halt_i = 1'b0;
         ifetch_ready_i = 1'b0;
         dmem_ready_i = 1'b0;
         opcode_i = (c < 7) ? 7'h23 : 7'h63;
         case (c)
            0, 1: sb.push_back(mk(S_IF, 1, 0, 0, 0, 0, 0, 0, 0, m));
            2: begin
               ifetch_ready_i = 1'b1;
               sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
            end
            3: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
            4: begin
               opcode_i = 7'h7f;
               sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m));
            end
            5: begin
               opcode_i = 7'h7f;
               dmem_ready_i = 1'b1;
               sb.push_back(mk(S_MEM, 0, 0, 1, 1, 0, 0, 0, 0, m));
            end
            6: sb.push_back(mk(S_WB, 0, 0, 0, 0, 0, 1, 0, 0, m));
            7: begin
               ifetch_ready_i = 1'b1;
               sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m + 1));
            end
            8: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m + 1));
            9: begin
               dmem_ready_i = 1'b1;
               sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m + 1));
            end
            default: sb.push_back(mk(S_WB, 0, 0, 0, 0, 0, 1, 0, 0, m + 1));
         endcase
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL st_br c%0d: got %h want %h", c, obs, exp_v);
         end
      end
      m = m + 2;
   endtask

   task automatic test_mem_timeout(input bit ready_last);
      logic ok;
      ok = ready_last;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         halt_i = 1'b0;
         opcode_i = 7'h03;
         ifetch_ready_i = (c == 0);
         dmem_ready_i = ready_last && (c == 18);
         if (c == 0)
            sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
         else if (c == 1)
            sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
         else if (c == 2)
            sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m));
         else if (c < 18)
            sb.push_back(mk(S_MEM, 0, 0, 1, 0, 0, 0, 0, 0, m));
         else if (c == 18)
            sb.push_back(mk(S_MEM, 0, 0, 1, 0, 0, 0, 0, !ok, m));
         else
            sb.push_back(mk(S_WB, 0, 0, 0, 0, ok, 1, 0, 0, m));
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL mem_to%0d c%0d: got %h want %h",
                     ready_last, c, obs, exp_v);
         end
      end
      if (ok) m = m + 1;
   endtask

   task automatic test_illegal_halt();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         halt_i = (c >= 4);
         opcode_i = 7'h7f;
         ifetch_ready_i = (c == 0) || (c >= 4);
         dmem_ready_i = 1'b0;
         case (c)
            0: sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
            1: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
            2: sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 1, 0, m));
            3: sb.push_back(mk(S_WB, 0, 0, 0, 0, 0, 1, 0, 0, m));
            default: sb.push_back(mk(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, m));
         endcase
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL ill_halt c%0d: got %h want %h", c, obs, exp_v);
         end
      end
   endtask

   task automatic test_if_timeout();
      for (int c = 0; c < 21; c++) begin
         @(negedge clk);
         halt_i = 1'b0;
         opcode_i = 7'h33;
         ifetch_ready_i = (c == 17);
         dmem_ready_i = 1'b0;
         if (c < 15 || c == 16)
            sb.push_back(mk(S_IF, 1, 0, 0, 0, 0, 0, 0, 0, m));
         else if (c == 15)
            sb.push_back(mk(S_IF, 1, 0, 0, 0, 0, 0, 0, 1, m));
         else if (c == 17)
            sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
         else if (c == 18)
            sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
         else if (c == 19)
            sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m));
         else
            sb.push_back(mk(S_WB, 0, 0, 0, 0, 1, 1, 0, 0, m));
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL if_to c%0d: got %h want %h", c, obs, exp_v);
         end
      end
      m = m + 1;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         halt_i = 1'b0;
         opcode_i = 7'h03;
         ifetch_ready_i = (c == 0);
         dmem_ready_i = 1'b0;
         case (c)
            0: sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
            1: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
            2: sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m));
            default: sb.push_back(mk(S_MEM, 0, 0, 1, 0, 0, 0, 0, 0, m));
         endcase
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL rst_mid c%0d: got %h want %h", c, obs, exp_v);
         end
      end
      #2;
      rst_i = 1'b1;
      sb.push_back(mk(S_IF, 1, 0, 0, 0, 0, 0, 0, 0, 32'd0));
      #1; exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL rst_async: got %h want %h", obs, exp_v);
      end
      @(negedge clk);
      dmem_ready_i = 1'b1;
      sb.push_back(mk(S_IF, 1, 0, 0, 0, 0, 0, 0, 0, 32'd0));
      #1; exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL rst_hold: got %h want %h", obs, exp_v);
      end
      rst_i = 1'b0;
      dmem_ready_i = 1'b0;
      m = 32'd0;
   endtask

   task automatic test_back_to_back();
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         halt_i = (c == 8);
         opcode_i = (c < 4) ? 7'h13 : 7'h37;
         ifetch_ready_i = (c == 0) || (c == 4);
         dmem_ready_i = 1'b0;
         case (c)
            0: sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m));
            1: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m));
            2: sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m));
            3: sb.push_back(mk(S_WB, 0, 0, 0, 0, 1, 1, 0, 0, m));
            4: sb.push_back(mk(S_IF, 1, 1, 0, 0, 0, 0, 0, 0, m + 1));
            5: sb.push_back(mk(S_ID, 0, 0, 0, 0, 0, 0, 0, 0, m + 1));
            6: sb.push_back(mk(S_EX, 0, 0, 0, 0, 0, 0, 0, 0, m + 1));
            7: sb.push_back(mk(S_WB, 0, 0, 0, 0, 1, 1, 0, 0, m + 1));
            default: sb.push_back(mk(S_IF, 0, 0, 0, 0, 0, 0, 0, 0, m + 2));
         endcase
         #1; exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) begin
            errors++;
            $display("FAIL b2b c%0d: got %h want %h", c, obs, exp_v);
         end
      end
      m = m + 2;
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load();
      test_store_branch();
      test_mem_timeout(1'b0);
      test_mem_timeout(1'b1);
      test_illegal_halt();
      test_if_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
